edg_pix_packer: RTL

Write-side counterpart of the edge-detect input unpacker. Accepts one processed 24-bit RGB pixel per clock from the edge-detect datapath and truncates each channel to 6 bits. Packs pixel pairs into the 36-bit two-pixel word format used by the ZBT frame buffer and issues buffered write requests to the memory arbiter. Sits between the edge-detect output and the ZBT write port.

---
 rtl/edg_pkg.sv | 14 +
 rtl/pix_fifo.sv | 53 +++++
 rtl/edg_pix_packer.sv | 115 +++++++++++
 3 files changed

// File: rtl/edg_pkg.sv
// Purpose: constants and pixel truncation shared by the edge-detect pixel packer and unpacker.
// Latency: none; this file holds only types, constants and a pure function.
// Backpressure: not applicable.
package edg_pkg;

   localparam int PIX_W  = 18;   // 6 bits per channel after truncation
   localparam int WORD_W = 36;   // two packed pixels per ZBT word

   // Keep the top 6 bits of each 8-bit channel: {R[7:2], G[7:2], B[7:2]}.
   function automatic logic [PIX_W-1:0] trunc24to18(input logic [23:0] rgb);
      return {rgb[23:18], rgb[15:10], rgb[7:2]};
   endfunction

endpackage

// File: rtl/pix_fifo.sv
// Purpose: synchronous write-buffer FIFO (push/pop, full/empty/fill), with a wrap bit on each pointer.
// Latency: a pushed entry is at the head one cycle after the push; a pop shows the next entry one cycle later.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle; a pop while empty is ignored.
// Ports: clk, reset (async, active-high), push/push_dat, pop, head (combinational), full, empty, fill.
module pix_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty = (wr_ptr == rd_ptr);
   // Same slot but different wrap bit: the writer has lapped the reader.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fill  = wr_ptr - rd_ptr;

   assign pop_ok  = pop && !empty;
   // When full, the slot being written is the one being popped this cycle.
   assign push_ok = push && (!full || pop_ok);

   assign head = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/edg_pix_packer.sv
// Purpose: truncate 24-bit RGB to 18 bits, pack pixel pairs into 36-bit ZBT words, and queue {addr, word} writes.
// Latency: a word completed in cycle N is at the head (wr_req=1) in cycle N+1 when the buffer was empty.
// Backpressure: the pixel stream cannot stall; a word pushed into a full buffer with no pop is dropped and sets sticky overflow.
// Ports: clk, reset; pix_valid/pix_rgb/eol/sof in; wr_req/wr_addr/wr_data out, wr_ack in; overflow, fill.
module edg_pix_packer
   import edg_pkg::*;
#(
   parameter int                ADDR_W     = 19,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          pix_valid,
   input  logic [23:0]                   pix_rgb,
   input  logic                          eol,
   input  logic                          sof,
   output logic                          wr_req,
   input  logic                          wr_ack,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [WORD_W-1:0]             wr_data,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fill
);

   localparam int ENT_W = WORD_W + ADDR_W;

   logic                phase;
   logic [PIX_W-1:0]    pending;
   logic [ADDR_W-1:0]   next_addr;

   logic [PIX_W-1:0]    pix18;
   logic                eff_phase;
   logic [ADDR_W-1:0]   eff_addr;
   logic                push_att;
   logic [WORD_W-1:0]   push_word;
   logic                pop;
   logic                drop;
   logic [ENT_W-1:0]    head;
   logic                full;
   logic                empty;

   assign pix18 = trunc24to18(pix_rgb);

   // sof acts before the pixel/eol of the same cycle: the pair restarts and
   // the address rewinds, so the current pixel sees phase 0 and BASE_ADDR.
   assign eff_phase = sof ? 1'b0 : phase;
   assign eff_addr  = sof ? BASE_ADDR : next_addr;

   always_comb begin
      push_att  = 1'b0;
      push_word = '0;
      if (pix_valid) begin
         if (eff_phase) begin
            push_att  = 1'b1;
            push_word = {pix18, pending};
         end else if (eol) begin
            push_att  = 1'b1;
            push_word = {{PIX_W{1'b0}}, pix18};
         end
      end else if (eol && eff_phase) begin
         push_att  = 1'b1;
         push_word = {{PIX_W{1'b0}}, pending};
      end
   end

   assign pop  = wr_req && wr_ack;
   assign drop = push_att && full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase     <= 1'b0;
         pending   <= '0;
         next_addr <= BASE_ADDR;
         overflow  <= 1'b0;
      end else begin
         // Dropped words still consume an address so later words keep their frame position.
         next_addr <= eff_addr + ADDR_W'(push_att);

         if (pix_valid && !eff_phase && !eol) begin
            pending <= pix18;
            phase   <= 1'b1;
         end else if (sof) begin
            pending <= '0;
            phase   <= 1'b0;
         end else if (push_att) begin
            phase   <= 1'b0;
         end

         // A drop in the same cycle as sof still counts: sof clears first.
         if (drop)     overflow <= 1'b1;
         else if (sof) overflow <= 1'b0;
      end
   end

   pix_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_att),
      .push_dat ({eff_addr, push_word}),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .fill     (fill)
   );

   assign wr_req  = !empty;
   assign wr_addr = empty ? '0 : head[ENT_W-1:WORD_W];
   assign wr_data = empty ? '0 : head[WORD_W-1:0];

endmodule
